rv_mem_arb: RTL and testbench



---
 rtl/rv_mem_arb.sv | 184 ++++++++++++++++++
 tb/tb_rv_mem_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
// rv_mem_arb -- single-port RAM arbiter between the rv_core fetch port (i_*)
// and data port (d_*).
//
// Each cycle one requester is granted the RAM. Data normally wins. A fetch
// that has been denied IWAIT_MAX cycles in a row wins once. Read data comes
// back one cycle after the grant and is steered by the registered owner.
// The i_rdy/d_rdy handshakes are registered and stall the core.
//
// Build option:
//   MEM_ARB_WBUF_EN  adds a one-entry posted write buffer. A write is absorbed
//                    without taking the RAM and drains later. Reads of a
//                    buffered word stall until that word has drained.
//
// Ports:
//   clk, xreset         clock; asynchronous active-low reset
//   i_adr/i_re          fetch request     -> i_dr/i_rdy fetch response
//   d_adr/d_re/d_we/d_dw data request     -> d_dr/d_rdy data response
//   m_adr/m_re/m_we/m_dw RAM command      <- m_dr RAM read data (1-cycle latency)
module rv_mem_arb #(
    parameter int IWAIT_MAX = 4,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          xreset,
    input  logic [31:0]   i_adr,
    input  logic          i_re,
    output logic [31:0]   i_dr,
    output logic          i_rdy,
    input  logic [31:0]   d_adr,
    input  logic          d_re,
    input  logic [3:0]    d_we,
    input  logic [31:0]   d_dw,
    output logic [31:0]   d_dr,
    output logic          d_rdy,
    output logic [AW-1:0] m_adr,
    output logic          m_re,
    output logic [3:0]    m_we,
    output logic [31:0]   m_dw,
    input  logic [31:0]   m_dr
);

    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_DR, OWN_DW} own_t;

    own_t          own;
    logic [3:0]    iwait;
    logic [31:0]   ilast;
    logic [AW-1:0] adr_q;      // last driven RAM address, held while idle
    logic [31:0]   dw_q;       // last driven RAM write data, held while idle

    logic          ireq, dwr, dreq, starve;
    logic          gnt_i;      // fetch owns the RAM this cycle
    logic          d_rd;       // data read issued to the RAM this cycle
    logic          d_acc;      // data request satisfied this cycle
    logic [AW-1:0] drv_adr;
    logic [3:0]    drv_we;
    logic [31:0]   drv_dw;

    assign ireq   = i_re;
    assign dwr    = |d_we;
    assign dreq   = d_re | dwr;
    assign starve = (iwait == 4'(IWAIT_MAX));

`ifdef MEM_ARB_WBUF_EN
    logic          wb_v;
    logic [AW-1:0] wb_adr;
    logic [3:0]    wb_we;
    logic [31:0]   wb_dw;
    logic          hazard, rd_req, drain_req, wb_drain, wb_cap;
    logic [AW-1:0] d_adr_w;

    assign d_adr_w = AW'(d_adr);
`endif

    // Grant and RAM drive. Grants are gated by xreset so that no access is
    // issued while reset is held, even if the core keeps requesting.
    always_comb begin
        gnt_i   = 1'b0;
        d_rd    = 1'b0;
        d_acc   = 1'b0;
        drv_adr = adr_q;
        drv_we  = 4'b0;
        drv_dw  = dw_q;
`ifdef MEM_ARB_WBUF_EN
        wb_drain  = 1'b0;
        wb_cap    = 1'b0;
        hazard    = d_re & wb_v & (d_adr_w[AW-1:2] == wb_adr[AW-1:2]);
        rd_req    = d_re & ~hazard;
        // A drain occupies the data slot. A read hitting the buffered word
        // forces the drain. Otherwise the read would wait forever, because
        // its own d_re blocks the idle-cycle drain.
        drain_req = wb_v & (hazard | dwr | (~ireq & ~d_re));
        if (xreset) begin
            gnt_i    = ireq & (starve | ~(rd_req | drain_req));
            d_rd     = rd_req & ~gnt_i;
            wb_drain = drain_req & ~gnt_i & ~d_rd;
            wb_cap   = dwr & (~wb_v | wb_drain);
        end
        d_acc = d_rd | wb_cap;
        if (wb_drain) begin
            drv_adr = wb_adr;
            drv_we  = wb_we;
            drv_dw  = wb_dw;
        end else if (d_rd) begin
            drv_adr = d_adr_w;
            drv_dw  = d_dw;
        end
`else
        if (xreset) begin
            gnt_i = ireq & (starve | ~dreq);
            d_acc = dreq & ~gnt_i;
        end
        d_rd = d_acc & d_re;
        if (d_acc) begin
            drv_adr = AW'(d_adr);
            drv_we  = d_we;
            drv_dw  = d_dw;
        end
`endif
        if (gnt_i) begin
            drv_adr = AW'(i_adr);
            drv_we  = 4'b0;
        end
    end

    assign m_adr = drv_adr;
    assign m_re  = gnt_i | d_rd;
    assign m_we  = drv_we;
    assign m_dw  = drv_dw;

    // Read steering for the access granted last cycle.
    assign i_dr = (own == OWN_I)  ? m_dr : ilast;
    assign d_dr = (own == OWN_DR) ? m_dr : 32'h0;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            adr_q <= '0;
            dw_q  <= '0;
            iwait <= '0;
            own   <= OWN_NONE;
            ilast <= '0;
            i_rdy <= 1'b1;
            d_rdy <= 1'b1;
        end else begin
            adr_q <= drv_adr;
            dw_q  <= drv_dw;
            if (!ireq || gnt_i)
                iwait <= '0;
            else if (!starve)
                iwait <= iwait + 4'd1;
            if (gnt_i)
                own <= OWN_I;
            else if (d_rd)
                own <= OWN_DR;
            else if (|drv_we)
                own <= OWN_DW;
            else
                own <= OWN_NONE;
            if (own == OWN_I)
                ilast <= m_dr;
            i_rdy <= ~ireq | gnt_i;
            d_rdy <= ~dreq | d_acc;
        end
    end

`ifdef MEM_ARB_WBUF_EN
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            wb_v   <= 1'b0;
            wb_adr <= '0;
            wb_we  <= '0;
            wb_dw  <= '0;
        end else if (wb_cap) begin
            // Capturing in a drain cycle replaces the drained entry.
            wb_v   <= 1'b1;
            wb_adr <= d_adr_w;
            wb_we  <= d_we;
            wb_dw  <= d_dw;
        end else if (wb_drain) begin
            wb_v   <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rv_mem_arb.sv
module tb_rv_mem_arb;
    localparam int IWAIT_MAX = 4;
    localparam int AW        = 32;

    logic          clk = 1'b0;
    logic          xreset;
    logic [31:0]   i_adr, d_adr, d_dw, m_dr, i_dr, d_dr, m_dw;
    logic          i_re, d_re, i_rdy, d_rdy, m_re;
    logic [3:0]    d_we, m_we;
    logic [AW-1:0] m_adr;

    int n_chk = 0;
    int n_err = 0;
    int we300 = 0;

    rv_mem_arb #(.IWAIT_MAX(IWAIT_MAX), .AW(AW)) dut (
        .clk(clk), .xreset(xreset),
        .i_adr(i_adr), .i_re(i_re), .i_dr(i_dr), .i_rdy(i_rdy),
        .d_adr(d_adr), .d_re(d_re), .d_we(d_we), .d_dw(d_dw),
        .d_dr(d_dr), .d_rdy(d_rdy),
        .m_adr(m_adr), .m_re(m_re), .m_we(m_we), .m_dw(m_dw), .m_dr(m_dr)
    );

    always #5 clk = ~clk;

    // Word k of the RAM starts as 0x1000_0000 + k; word 0x200/4 has
    // non-zero neighbour bytes so a byte write shows they survive.
    function automatic logic [31:0] init_word(int k);
        return (k == 128) ? 32'h1100_0022 : 32'h1000_0000 + 32'(k);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous RAM, 1-cycle read latency, byte write enables.
    logic [31:0] ram [1024];
    initial begin
        m_dr <= 32'h0;
        for (int k = 0; k < 1024; k++) ram[k] <= init_word(k);
        forever begin
            @(posedge clk);
            if (m_re) m_dr <= ram[m_adr[11:2]];
            for (int b = 0; b < 4; b++)
                if (m_we[b]) ram[m_adr[11:2]][8*b +: 8] <= m_dw[8*b +: 8];
        end
    end

    always @(posedge clk)
        if (m_we != 4'b0 && m_adr == 32'h300) we300 <= we300 + 1;

`ifndef MEM_ARB_WBUF_EN
    // Reference model: arbitration decided from request flags and a count of
    // consecutive denied fetch cycles; responses taken from a shadow memory.
    logic [31:0] ref_mem [1024];
    initial begin
        int          wcnt, rsp;
        logic [31:0] hold_adr, hold_dw, last_fetch, rsp_data;
        logic [31:0] e_adr, e_dw, e_idr, e_ddr;
        logic [3:0]  e_we;
        logic        e_re, e_irdy, e_drdy, ireq, dreq, take_i, take_d;
        for (int k = 0; k < 1024; k++) ref_mem[k] = init_word(k);
        wcnt = 0; rsp = 0; hold_adr = 0; hold_dw = 0; last_fetch = 0; rsp_data = 0;
        e_irdy = 1; e_drdy = 1; ireq = 0; dreq = 0; take_i = 0; take_d = 0;
        forever begin
            @(negedge clk);
            if (!xreset) begin
                wcnt = 0; rsp = 0; hold_adr = 0; hold_dw = 0; last_fetch = 0;
                e_irdy = 1; e_drdy = 1; take_i = 0; take_d = 0;
            end else begin
                ireq   = i_re;
                dreq   = d_re || (d_we != 4'b0);
                take_i = ireq && (wcnt >= IWAIT_MAX || !dreq);
                take_d = dreq && !take_i;
            end
            e_adr = take_i ? i_adr : (take_d ? d_adr : hold_adr);
            e_dw  = take_d ? d_dw : hold_dw;
            e_re  = take_i || (take_d && d_re);
            e_we  = take_d ? d_we : 4'b0;
            e_idr = (rsp == 1) ? rsp_data : last_fetch;
            e_ddr = (rsp == 2) ? rsp_data : 32'h0;
            chk("model_m_adr", m_adr, e_adr);
            chk("model_m_dw",  m_dw,  e_dw);
            chk("model_m_re",  32'(m_re), 32'(e_re));
            chk("model_m_we",  32'(m_we), 32'(e_we));
            chk("model_i_dr",  i_dr,  e_idr);
            chk("model_d_dr",  d_dr,  e_ddr);
            chk("model_i_rdy", 32'(i_rdy), 32'(e_irdy));
            chk("model_d_rdy", 32'(d_rdy), 32'(e_drdy));
            if (xreset) begin
                if (rsp == 1) last_fetch = rsp_data;
                rsp_data = ref_mem[e_adr[11:2]];
                rsp = take_i ? 1 : ((take_d && d_re) ? 2 : 0);
                if (take_d)
                    for (int b = 0; b < 4; b++)
                        if (d_we[b]) ref_mem[d_adr[11:2]][8*b +: 8] = d_dw[8*b +: 8];
                hold_adr = e_adr;
                hold_dw  = e_dw;
                e_irdy = !ireq || take_i;
                e_drdy = !dreq || take_d;
                wcnt = (ireq && !take_i) ? ((wcnt < IWAIT_MAX) ? wcnt + 1 : wcnt) : 0;
            end
        end
    end
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        xreset = 1'b0;
        i_re = 0; i_adr = 0; d_re = 0; d_we = 0; d_adr = 0; d_dw = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_rdy", 32'(i_rdy), 32'd1);
        chk("rst_d_rdy", 32'(d_rdy), 32'd1);
        chk("rst_m_re",  32'(m_re),  32'd0);
        chk("rst_m_adr", m_adr, 32'h0);
        chk("rst_i_dr",  i_dr,  32'h0);
        chk("rst_d_dr",  d_dr,  32'h0);
        xreset = 1'b1;
        tick();

        // Fetch-only stream.
        for (int k = 0; k < 3; k++) begin
            i_re = 1; i_adr = 32'(4 * k);
            #1 chk("fetch_m_adr", m_adr, 32'(4 * k));
            chk("fetch_m_re", 32'(m_re), 32'd1);
            tick();
            chk("fetch_i_dr",  i_dr, 32'h1000_0000 + 32'(k));
            chk("fetch_i_rdy", 32'(i_rdy), 32'd1);
            chk("fetch_d_dr",  d_dr, 32'h0);
        end
        i_re = 0;
        tick();
        chk("idle_ilast", i_dr, 32'h1000_0002);

        // Fetch and data read together: data wins, fetch follows.
        i_re = 1; i_adr = 32'h40; d_re = 1; d_adr = 32'h100;
        #1 chk("both_m_adr", m_adr, 32'h100);
        tick();
        chk("both_d_dr",  d_dr, 32'h1000_0040);
        chk("both_d_rdy", 32'(d_rdy), 32'd1);
        chk("both_i_rdy", 32'(i_rdy), 32'd0);
        chk("both_i_dr",  i_dr, 32'h1000_0002);
        d_re = 0;
        #1 chk("then_m_adr", m_adr, 32'h40);
        tick();
        chk("then_i_dr",  i_dr, 32'h1000_0010);
        chk("then_i_rdy", 32'(i_rdy), 32'd1);
        i_re = 0;
        tick();

        // Continuous contention: fetch wins every 5th cycle.
        i_re = 1; i_adr = 32'h80; d_re = 1; d_adr = 32'h104;
        for (int c = 0; c < 10; c++) begin
            #1 chk("starve_m_adr", m_adr, (c % 5 == 4) ? 32'h80 : 32'h104);
            tick();
            chk("starve_i_rdy", 32'(i_rdy), (c % 5 == 4) ? 32'd1 : 32'd0);
            chk("starve_d_rdy", 32'(d_rdy), (c % 5 == 4) ? 32'd0 : 32'd1);
        end
        i_re = 0; d_re = 0;
        tick();

`ifndef MEM_ARB_WBUF_EN
        // Byte write then readback.
        d_we = 4'b0100; d_adr = 32'h200; d_dw = 32'h00AB_0000;
        #1 chk("bw_m_we", 32'(m_we), 32'h4);
        chk("bw_m_re", 32'(m_re), 32'd0);
        tick();
        chk("bw_d_rdy", 32'(d_rdy), 32'd1);
        d_we = 0; d_re = 1;
        #1 chk("br_m_re", 32'(m_re), 32'd1);
        tick();
        chk("br_d_dr",  d_dr, 32'h11AB_0022);
        chk("br_d_rdy", 32'(d_rdy), 32'd1);
        d_re = 0;
        tick();
`else
        // Posted write followed by a read of the same word.
        d_we = 4'hF; d_adr = 32'h300; d_dw = 32'hCAFE_F00D;
        #1 chk("wb_cap_m_we", 32'(m_we), 32'h0);
        tick();
        chk("wb_cap_d_rdy", 32'(d_rdy), 32'd1);
        d_we = 0; d_re = 1;
        #1 chk("wb_drain_m_we", 32'(m_we), 32'hF);
        chk("wb_drain_m_adr", m_adr, 32'h300);
        tick();
        chk("wb_stall_d_rdy", 32'(d_rdy), 32'd0);
        #1 chk("wb_rd_m_re", 32'(m_re), 32'd1);
        chk("wb_rd_m_we", 32'(m_we), 32'h0);
        tick();
        chk("wb_rd_d_rdy", 32'(d_rdy), 32'd1);
        chk("wb_rd_d_dr",  d_dr, 32'hCAFE_F00D);
        d_re = 0;
        tick();
        chk("wb_we_count", 32'(we300), 32'd1);
`endif

        // Reset in the middle of a fetch grant.
        i_re = 1; i_adr = 32'hC;
        #1 chk("mid_m_re", 32'(m_re), 32'd1);
        #1 xreset = 1'b0;
        #1 chk("mid_rst_m_re",  32'(m_re), 32'd0);
        chk("mid_rst_m_adr", m_adr, 32'h0);
        chk("mid_rst_i_dr",  i_dr,  32'h0);
        chk("mid_rst_i_rdy", 32'(i_rdy), 32'd1);
        chk("mid_rst_d_rdy", 32'(d_rdy), 32'd1);
        i_re = 0;
        tick();
        tick();
        xreset = 1'b1;
        #1 chk("post_rst_ilast", i_dr, 32'h0);
        i_re = 1;
        tick();
        chk("post_rst_i_dr", i_dr, 32'h1000_0003);
        i_re = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
